// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (5..8 data bits, optional odd/even parity) feeding a first-word fall-through receive FIFO.
// Latency: a word shows on rxbyte/ready one clk after the stop-bit sample, plus 2 clk of rx synchroniser.
// Backpressure: none on the serial line; a word arriving while the FIFO is full (with no pop that cycle) is dropped and sets overrun.
//
// Optional feature macro: UART_RX_MAJORITY_EN. When defined, each START/DATA/PARITY/STOP sample
// is the 2-of-3 majority of rxs at the decision cycle and the two cycles before it.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx         serial line (asynchronous, idle high)
//   rxread     single-cycle pop of the head word (ignored while ready=0)
//   rxbyte     head-of-FIFO word, valid while ready=1 (0 when empty)
//   ready      FIFO not empty
//   level      number of words held, 0..FIFO_DEPTH
//   frame_err  sticky: stop bit sampled low
//   parity_err sticky: parity mismatch on an accepted word
//   overrun    sticky: word dropped because the FIFO was full
//   err_clr    single-cycle pulse clearing the three sticky flags
module uart_rx_fifo #(
    parameter int CLK_DIV    = 1042,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rxread,
    output logic [DATA_BITS-1:0]          rxbyte,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int CW  = $clog2(CLK_DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // ---------------- input synchroniser / sampling ----------------
    logic rx_meta, rxs, rxs_d;
    logic samp;
    logic fall;

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            rxs_d2  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
            rxs_d2  <= rxs_d;
        end
    end

    // 2-of-3 vote over the decision cycle and the two cycles before it
    assign samp = (rxs & rxs_d) | (rxs & rxs_d2) | (rxs_d & rxs_d2);
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign samp = rxs;
`endif

    // Edge rather than level: after a break the line must go high and fall
    // again before another frame is started.
    assign fall = rxs_d & ~rxs;

    // ---------------- frame FSM ----------------
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    logic tick_half, tick_bit;
    logic push, ferr_evt, perr_evt;

    assign tick_half = (cnt == HALF);
    assign tick_bit  = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) state <= START;
                end
                START: begin
                    if (tick_half) begin
                        cnt     <= '0;
                        idx     <= '0;
                        par_bad <= 1'b0;
                        // line back high at mid start bit: glitch, not a frame
                        state   <= samp ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_bit) begin
                        cnt        <= '0;
                        shreg[idx] <= samp;
                        if (idx == LAST_IDX) state <= (PARITY != 0) ? PAR : STOP;
                        else                 idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (tick_bit) begin
                        cnt     <= '0;
                        // odd: data^parity must be 1; even: must be 0
                        par_bad <= (PARITY == 1) ? ~(^shreg ^ samp) : (^shreg ^ samp);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_bit) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frame outcome is decided on the stop-bit sample itself so the FIFO
    // write lands on that same edge.
    assign push     = (state == STOP) && tick_bit && samp;
    assign ferr_evt = (state == STOP) && tick_bit && !samp;
    assign perr_evt = push && par_bad;

    // ---------------- receive FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 full, pop, wr_en, ovr_evt;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = rxread && ready;
    // a pop in the same cycle frees the slot the incoming word needs
    assign wr_en   = push && (!full || pop);
    assign ovr_evt = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign ready  = (level != '0);
    assign rxbyte = ready ? mem[rd_ptr] : '0;

    // ---------------- sticky error flags (event beats clear) ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (ferr_evt)     frame_err  <= 1'b1;
            else if (err_clr) frame_err  <= 1'b0;
            if (perr_evt)     parity_err <= 1'b1;
            else if (err_clr) parity_err <= 1'b0;
            if (ovr_evt)      overrun    <= 1'b1;
            else if (err_clr) overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1/depth 4, 7E/depth 8 at div 20, 5O/depth 2),
// random and directed frames, scoreboard queues popped by a negedge monitor.
module tb_uart_rx_fifo;

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    localparam int DIV [3] = '{16, 20, 16};
    localparam int DB  [3] = '{8, 7, 5};
    localparam int PAR [3] = '{0, 2, 1};
    localparam int DEP [3] = '{4, 8, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n, rx_line, rd_en, rd_force, clr;
    logic [2:0] rdy, fe, pe, ov;
    wire  [2:0] rxr = rd_en | rd_force;

    logic [7:0] rb_a;
    logic [6:0] rb_b;
    logic [4:0] rb_c;
    logic [2:0] lv_a;
    logic [3:0] lv_b;
    logic [1:0] lv_c;

    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_n[0]), .rx(rx_line[0]), .rxread(rxr[0]), .rxbyte(rb_a),
        .ready(rdy[0]), .level(lv_a), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]),
        .err_clr(clr[0]));
    uart_rx_fifo #(.CLK_DIV(20), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .reset(rst_n[1]), .rx(rx_line[1]), .rxread(rxr[1]), .rxbyte(rb_b),
        .ready(rdy[1]), .level(lv_b), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]),
        .err_clr(clr[1]));
    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(5), .PARITY(1), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .reset(rst_n[2]), .rx(rx_line[2]), .rxread(rxr[2]), .rxbyte(rb_c),
        .ready(rdy[2]), .level(lv_c), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]),
        .err_clr(clr[2]));

    int n_chk = 0;
    int n_fail = 0;

    // reference model: expected FIFO contents and sticky flags per instance
    int q0[$], q1[$], q2[$];
    bit [2:0] e_fe, e_pe, e_ov;

    function automatic int rbyte(input int d);
        case (d)
            0: return int'(rb_a);
            1: return int'(rb_b);
            default: return int'(rb_c);
        endcase
    endfunction

    function automatic int lvl(input int d);
        case (d)
            0: return int'(lv_a);
            1: return int'(lv_b);
            default: return int'(lv_c);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int q_head(input int d);
        case (d)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_push(input int d, input int w);
        case (d)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic q_pop(input int d, output int w);
        case (d)
            0: w = q0.pop_front();
            1: w = q1.pop_front();
            default: w = q2.pop_front();
        endcase
    endtask

    task automatic q_clear(input int d);
        case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: every accepted pop is compared against the scoreboard head
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n[d] && rxr[d] && rdy[d]) begin
                if (q_size(d) == 0) begin
                    chk($sformatf("pop_unexpected_%0d", d), rbyte(d), -1);
                end else begin
                    int w;
                    q_pop(d, w);
                    chk($sformatf("pop_word_%0d", d), rbyte(d), w);
                end
            end
        end
    end

    task automatic check_state(input int d, input string tag);
        @(negedge clk);
        chk($sformatf("%s_level_%0d", tag, d), lvl(d), q_size(d));
        chk($sformatf("%s_ready_%0d", tag, d), int'(rdy[d]), int'(q_size(d) != 0));
        chk($sformatf("%s_frame_err_%0d", tag, d), int'(fe[d]), int'(e_fe[d]));
        chk($sformatf("%s_parity_err_%0d", tag, d), int'(pe[d]), int'(e_pe[d]));
        chk($sformatf("%s_overrun_%0d", tag, d), int'(ov[d]), int'(e_ov[d]));
        if (q_size(d) != 0) chk($sformatf("%s_head_%0d", tag, d), rbyte(d), q_head(d));
    endtask

    task automatic set_rd(input int d, input bit v);
        @(posedge clk);
        #1 rd_en[d] = v;
    endtask

    task automatic err_pulse(input int d);
        @(posedge clk);
        #1 clr[d] = 1'b1;
        e_fe[d] = 1'b0; e_pe[d] = 1'b0; e_ov[d] = 1'b0;
        @(posedge clk);
        #1 clr[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while ((q_size(d) != 0 || rdy[d]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("drain_left_%0d", d), q_size(d), 0);
    endtask

    // Drives one frame. act: 1 = rxread, 2 = err_clr in the cycle the word is written.
    // spike: 1-clk inversion at the centre of every data bit. cut >= 0 stops after that many cycles.
    task automatic send_frame(input int d, input int data, input bit flip, input bit stop_v,
                              input bit spike, input int act, input bit lat, input int cut);
        int  dv   = DIV[d];
        int  h    = dv / 2;
        int  nb   = DB[d];
        int  mask = (1 << nb) - 1;
        int  dat  = data & mask;
        int  seen;
        bit  pb   = 1'b0;
        bit  bad  = 1'b0;
        bit  abort = 1'b0;
        bit  line[$];
        line.push_back(1'b0);
        for (int i = 0; i < nb; i++) line.push_back(bit'((dat >> i) & 1));
        if (PAR[d] != 0) begin
            pb = bit'($countones(dat) & 1);
            if (PAR[d] == 1) pb = ~pb;
            pb = pb ^ flip;
            line.push_back(pb);
        end
        line.push_back(stop_v);
        seen = (spike && !MAJ) ? (~dat & mask) : dat;
        if (PAR[d] != 0) bad = ((($countones(seen) + int'(pb)) & 1) != (PAR[d] == 1 ? 1 : 0));
        for (int k = 0; k < line.size() && !abort; k++) begin
            for (int c = 0; c < dv; c++) begin
                if (cut >= 0 && k * dv + c >= cut) begin
                    abort = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
                rx_line[d] = (spike && k >= 1 && k <= nb && c == h + 1) ? ~line[k] : line[k];
                if (k == line.size() - 1) begin
                    if (c == 0) begin
                        if (!stop_v) e_fe[d] = 1'b1;
                        else begin
                            if (q_size(d) < DEP[d] || act == 1) q_push(d, seen);
                            else e_ov[d] = 1'b1;
                            if (bad) e_pe[d] = 1'b1;
                        end
                    end
                    rd_force[d] = (c == h + 3) && (act == 1);
                    clr[d]      = (c == h + 3) && (act == 2);
                    if (c == h + 3 && act == 2) begin
                        e_fe[d] = 1'b0; e_ov[d] = 1'b0; e_pe[d] = bad;
                    end
                    if (lat && (c == h + 3 || c == h + 4)) begin
                        @(negedge clk);
                        chk($sformatf("ready_latency_c%0d_%0d", c, d), int'(rdy[d]), int'(c == h + 4));
                    end
                end
            end
        end
        rd_force[d] = 1'b0;
        clr[d] = 1'b0;
        if (abort) rx_line[d] = 1'b1;
        else if (!stop_v) begin
            @(posedge clk);
            #1 rx_line[d] = 1'b1;
        end
    endtask

    initial begin
        int w [5];
        rx_line = '1; rst_n = '0; rd_en = '0; rd_force = '0; clr = '0;
        e_fe = '0; e_pe = '0; e_ov = '0;
        repeat (3) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            check_state(d, "reset");
            chk($sformatf("reset_rxbyte_%0d", d), rbyte(d), 0);
        end
        @(posedge clk);
        #1 rst_n = '1;
        repeat (4) @(posedge clk);

        // back-to-back 8N1 frames, reads held off
        send_frame(0, 'hA5, 0, 1, 0, 0, 1, -1);
        send_frame(0, 'h3C, 0, 1, 0, 0, 0, -1);
        check_state(0, "b2b");
        set_rd(0, 1);
        drain(0);
        check_state(0, "b2b_drained");

        // even parity: bad, clear, good, error event against clear
        send_frame(1, 'h07, 1, 1, 0, 0, 0, -1);
        check_state(1, "par_bad");
        err_pulse(1);
        check_state(1, "par_clr");
        send_frame(1, 'h07, 0, 1, 0, 0, 0, -1);
        check_state(1, "par_ok");
        send_frame(1, 'h2A, 1, 1, 0, 2, 0, -1);
        check_state(1, "evt_vs_clr");
        err_pulse(1);
        set_rd(1, 1);
        drain(1);

        // break: 20 bit periods low gives exactly one frame error
        for (int j = 0; j < 20 * 16; j++) begin
            @(posedge clk);
            #1 rx_line[0] = 1'b0;
            clr[0] = (j == 12 * 16);
            if (j == 12 * 16) begin
                chk("break_frame_err", int'(fe[0]), 1);
                e_fe[0] = 1'b0;
            end
        end
        clr[0] = 1'b0;
        check_state(0, "break_end");
        @(posedge clk);
        #1 rx_line[0] = 1'b1;
        repeat (32) @(posedge clk);
        send_frame(0, 'h55, 0, 1, 0, 0, 0, -1);
        drain(0);
        check_state(0, "after_break");

        // overrun: five frames into a depth-4 FIFO
        set_rd(0, 0);
        for (int i = 0; i < 5; i++) begin
            w[i] = int'($urandom_range(0, 255));
            send_frame(0, w[i], 0, 1, 0, 0, 0, -1);
        end
        check_state(0, "overrun");
        set_rd(0, 1);
        drain(0);
        err_pulse(0);
        set_rd(0, 0);
        for (int i = 0; i < 5; i++) begin
            w[i] = int'($urandom_range(0, 255));
            send_frame(0, w[i], 0, 1, 0, (i == 4) ? 1 : 0, 0, -1);
        end
        check_state(0, "full_pop_push");
        set_rd(0, 1);
        drain(0);

        // quarter-bit glitch is a false start
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1 rx_line[0] = 1'b0;
        end
        @(posedge clk);
        #1 rx_line[0] = 1'b1;
        repeat (48) @(posedge clk);
        check_state(0, "glitch");

        // reset mid-DATA with a word held and frame_err set
        set_rd(0, 0);
        send_frame(0, 'h3C, 0, 1, 0, 0, 0, -1);
        send_frame(0, 'h5A, 0, 0, 0, 0, 0, -1);
        check_state(0, "pre_reset");
        send_frame(0, 'hFF, 0, 1, 0, 0, 0, 4 * 16);
        @(posedge clk);
        #1 rst_n[0] = 1'b0;
        q_clear(0); e_fe[0] = 1'b0; e_pe[0] = 1'b0; e_ov[0] = 1'b0;
        check_state(0, "mid_reset");
        chk("mid_reset_rxbyte", rbyte(0), 0);
        @(posedge clk);
        #1 rst_n[0] = 1'b1;
        repeat (4) @(posedge clk);
        send_frame(0, 'h81, 0, 1, 0, 0, 0, -1);
        check_state(0, "post_reset");
        set_rd(0, 1);
        drain(0);

        // 5O1: spiked data bits, then random frames
        set_rd(2, 1);
        send_frame(2, 'h13, 0, 1, 1, 0, 0, -1);
        drain(2);
        check_state(2, "spike");
        err_pulse(2);
        for (int i = 0; i < 4; i++)
            send_frame(2, int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), 1, 0, 0, 0, -1);
        drain(2);
        check_state(2, "rand_odd");

        // 7E1 random back-to-back burst
        for (int i = 0; i < 6; i++)
            send_frame(1, int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)), 1, 0, 0, 0, -1);
        drain(1);
        check_state(1, "rand_even");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
